serializer: RTL and testbench

Parallel-to-serial shift stage of the UART transmitter. It captures a DATA_WIDTH-bit word when the upstream source signals valid data. It then shifts the word out one bit per enabled clock, LSB first, under control of the TX FSM's ser_en. It flags the last bit with ser_done so the FSM can advance to the parity/stop phase.

---
 rtl/serializer_pkg.sv | 18 +
 rtl/ser_bit_counter.sv | 36 +++
 rtl/serializer.sv | 88 ++++++++
 tb/tb_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// Optional build macro SER_MSB_FIRST_EN selects MSB-first shifting (see serializer.sv).
package serializer_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_W          = $clog2(DATA_WIDTH_DEF);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // Counter width for an arbitrary word width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: sync clear, enable, and a
// terminal-count flag that wraps the count back to zero on the last bit.
module ser_bit_counter #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial shift stage of the UART transmitter, LSB first by default.
// Define SER_MSB_FIRST_EN to shift MSB first; counter and ser_done timing are identical.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int                  CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]       LAST = CW'(DATA_WIDTH - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic                    cnt_clear;
  logic                    cnt_en;
  logic                    cnt_tc;

  ser_bit_counter #(
    .WIDTH (CW),
    .LAST  (LAST)
  ) u_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          shift_d   = P_DATA;
          cnt_clear = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Load requests are ignored here; only ser_en advances the word.
        if (ser_en) begin
`ifdef SER_MSB_FIRST_EN
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
`else
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
`endif
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

`ifdef SER_MSB_FIRST_EN
  assign ser_data = shift_q[DATA_WIDTH-1];
`else
  assign ser_data = shift_q[0];
`endif

  assign ser_done = (state_q == S_SHIFT) & ser_en & cnt_tc;

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer (8-bit word).
// Expected bit order follows SER_MSB_FIRST_EN when the bench is built with it.
module tb_serializer;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       ser_en;
  logic       ser_data;
  logic       ser_done;

  int vectors;
  int miscompares;

  serializer #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .ser_done   (ser_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit expected on the line in the cycle where the word's bit counter is k.
  function automatic logic exp_bit(input logic [7:0] word, input int k);
`ifdef SER_MSB_FIRST_EN
    return word[7-k];
`else
    return word[k];
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; Data_Valid = 1'b1; ser_en = 1'b1; P_DATA = 8'hFF;
    tick();
    tick();
    vectors++;
    if (ser_data !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ser_data got=%b exp=0", ser_data);
    end
    vectors++;
    if (ser_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ser_done got=%b exp=0", ser_done);
    end
    // Reset won over Data_Valid, so no word was loaded.
    RST = 1'b0; Data_Valid = 1'b0;
    tick();
    vectors++;
    if (ser_data !== 1'b0 || ser_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_load got=%b/%b exp=0/0", ser_data, ser_done);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] word;
    word = 8'hBB;
    P_DATA = word; Data_Valid = 1'b1; ser_en = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (ser_data !== exp_bit(word, k) || ser_done !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL single_bit%0d got=%b/%b exp=%b/%b", k, ser_data, ser_done,
                 exp_bit(word, k), (k == 7));
      end
      tick();
    end
    vectors++;
    if (ser_data !== 1'b0 || ser_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle got=%b/%b exp=0/0", ser_data, ser_done);
    end
    tick();
    vectors++;
    if (ser_data !== exp_bit(word, 0) || ser_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_reload got=%b/%b exp=%b/0", ser_data, ser_done, exp_bit(word, 0));
    end
    Data_Valid = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_pause();
    logic [7:0] word;
    word = 8'hA5;
    P_DATA = word; Data_Valid = 1'b1; ser_en = 1'b1;
    tick();
    Data_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ser_data !== exp_bit(word, k) || ser_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL pause_pre_bit%0d got=%b/%b exp=%b/0", k, ser_data, ser_done, exp_bit(word, k));
      end
      tick();
    end
    ser_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (ser_data !== exp_bit(word, 2) || ser_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL pause_hold%0d got=%b/%b exp=%b/0", c, ser_data, ser_done, exp_bit(word, 2));
      end
      tick();
    end
    ser_en = 1'b1;
    #1;
    for (int k = 2; k < 8; k++) begin
      vectors++;
      if (ser_data !== exp_bit(word, k) || ser_done !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL pause_post_bit%0d got=%b/%b exp=%b/%b", k, ser_data, ser_done,
                 exp_bit(word, k), (k == 7));
      end
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    P_DATA = 8'h0F; Data_Valid = 1'b1; ser_en = 1'b1;
    tick();
    Data_Valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        P_DATA = 8'hF0; Data_Valid = 1'b1;
      end else begin
        Data_Valid = 1'b0;
      end
      #1;
      vectors++;
      if (ser_data !== exp_bit(8'h0F, k) || ser_done !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL busy_bit%0d got=%b/%b exp=%b/%b", k, ser_data, ser_done,
                 exp_bit(8'h0F, k), (k == 7));
      end
      tick();
    end
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (ser_data !== exp_bit(8'hF0, k) || ser_done !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL busy_next_bit%0d got=%b/%b exp=%b/%b", k, ser_data, ser_done,
                 exp_bit(8'hF0, k), (k == 7));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    P_DATA = 8'hFF; Data_Valid = 1'b1; ser_en = 1'b1;
    tick();
    Data_Valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if (ser_data !== 1'b1 || ser_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_bit4 got=%b/%b exp=1/0", ser_data, ser_done);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (ser_data !== 1'b0 || ser_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_after%0d got=%b/%b exp=0/0", c, ser_data, ser_done);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    P_DATA = 8'h3C; Data_Valid = 1'b1; ser_en = 1'b1;
    tick();
    P_DATA = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (ser_data !== exp_bit(8'h3C, k) || ser_done !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL b2b_w0_bit%0d got=%b/%b exp=%b/%b", k, ser_data, ser_done,
                 exp_bit(8'h3C, k), (k == 7));
      end
      tick();
    end
    // One idle load cycle separates consecutive words.
    vectors++;
    if (ser_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap got=%b exp=0", ser_done);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (ser_data !== exp_bit(8'hC3, k) || ser_done !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL b2b_w1_bit%0d got=%b/%b exp=%b/%b", k, ser_data, ser_done,
                 exp_bit(8'hC3, k), (k == 7));
      end
      tick();
    end
    Data_Valid = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1; Data_Valid = 1'b0; ser_en = 1'b0; P_DATA = 8'h00;
    #1;
    test_reset();
    test_single_word();
    test_pause();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
